// File: rtl/svm_linear_classifier.sv
// Linear multi-class SVM inference: one shared signed MAC walks every class's weights and keeps the
// best score seen so far. Weights and biases live in a write-port register file that reset leaves intact.
module svm_linear_classifier #(
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int NUM_FEAT  = 5,
  parameter int NUM_CLASS = 5,
  localparam int CLS_W  = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1,
  localparam int ADDR_W = $clog2(NUM_CLASS * (NUM_FEAT + 1)),
  localparam int ACC_W  = 2 * DATA_W + $clog2(NUM_FEAT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_FEAT*DATA_W-1:0]   feat_in,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         busy,
  output logic                         valid,
  output logic [CLS_W-1:0]             class_out,
  output logic [DATA_W-1:0]            score_out,
  output logic                         sat
);

  localparam int FEAT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int TOTAL  = NUM_CLASS * (NUM_FEAT + 1);
  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0]   w_mem [TOTAL];
  logic [NUM_FEAT*DATA_W-1:0] feat_q;
  logic [CLS_W-1:0]           c_cnt;
  logic [FEAT_W-1:0]          f_cnt;
  logic signed [ACC_W-1:0]    acc;
  logic signed [DATA_W-1:0]   best;
  logic [CLS_W-1:0]           best_idx;
  logic                       sat_run;

  logic                       last_feat, last_class, wr_ok;
  logic [ADDR_W-1:0]          base_addr, rd_w_addr, rd_b_addr;
  logic signed [DATA_W-1:0]   w_val, b_val, x_val;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    bias_acc, acc_next, shifted;
  logic signed [DATA_W-1:0]   s_val;
  logic                       s_sat;

  // Handshake: start is accepted on a clock edge while busy==0; busy is high from the next cycle until
  // the one-cycle valid pulse, during which busy is already low and a new start may be accepted.
  assign busy       = (state != IDLE);
  assign last_feat  = (f_cnt == FEAT_W'(NUM_FEAT - 1));
  assign last_class = (c_cnt == CLS_W'(NUM_CLASS - 1));
  assign wr_ok      = wr_en && (state == IDLE) && ({1'b0, wr_addr} < (ADDR_W+1)'(TOTAL));

  always_ff @(posedge clk) begin
    if (wr_ok) w_mem[wr_addr] <= wr_data;
  end

  always_comb begin
    base_addr = ADDR_W'(c_cnt) * ADDR_W'(NUM_FEAT + 1);
    rd_w_addr = base_addr + ADDR_W'(f_cnt);
    rd_b_addr = base_addr + ADDR_W'(NUM_FEAT);
    w_val     = w_mem[rd_w_addr];
    b_val     = w_mem[rd_b_addr];
    x_val     = feat_q[f_cnt*DATA_W +: DATA_W];
    prod      = w_val * x_val;
    bias_acc  = ACC_W'(b_val);
    bias_acc  = bias_acc <<< FRAC_W;
    acc_next  = (f_cnt == '0) ? bias_acc + ACC_W'(prod) : acc + ACC_W'(prod);
    // Back to the Q format of the inputs, clamped to the signed output range.
    shifted   = acc >>> FRAC_W;
    s_sat     = 1'b0;
    s_val     = shifted[DATA_W-1:0];
    if (shifted > S_MAX) begin
      s_val = S_MAX[DATA_W-1:0];
      s_sat = 1'b1;
    end else if (shifted < S_MIN) begin
      s_val = S_MIN[DATA_W-1:0];
      s_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MAC;
      MAC:     if (last_feat) state_next = CMP;
      CMP:     state_next = last_class ? DONE : MAC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feat_q    <= '0;
      c_cnt     <= '0;
      f_cnt     <= '0;
      acc       <= '0;
      best      <= '0;
      best_idx  <= '0;
      sat_run   <= 1'b0;
      valid     <= 1'b0;
      class_out <= '0;
      score_out <= '0;
      sat       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            feat_q  <= feat_in;
            c_cnt   <= '0;
            f_cnt   <= '0;
            sat_run <= 1'b0;
          end
        end
        MAC: begin
          acc   <= acc_next;
          f_cnt <= last_feat ? '0 : f_cnt + 1'b1;
        end
        CMP: begin
          if (s_sat) sat_run <= 1'b1;
          // Strict greater-than keeps the lower index on ties.
          if ((c_cnt == '0) || (s_val > best)) begin
            best     <= s_val;
            best_idx <= c_cnt;
          end
          if (!last_class) c_cnt <= c_cnt + 1'b1;
        end
        DONE: begin
          valid     <= 1'b1;
          class_out <= best_idx;
          score_out <= best;
          sat       <= sat_run;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_linear_classifier.sv
// Directed bench for svm_linear_classifier: expected results are queued at start and checked
// by a monitor whenever valid pulses, including the exact accept-to-valid latency.
module tb_svm_linear_classifier;
  localparam int DW = 16;
  localparam int F  = 5;
  localparam int CW = 3;
  localparam int AW = 5;
  localparam int LAT = 32;  // drive cycle + 1 accept edge + 31 cycles to valid

  logic            clk = 1'b0;
  logic            rst, start, wr_en;
  logic [F*DW-1:0] feat_in;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            busy, valid, sat;
  logic [CW-1:0]   class_out;
  logic [DW-1:0]   score_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [19:0] exp_q[$];
  int          exp_t_q[$];
  logic [19:0] mon_e;
  int          mon_t;

  svm_linear_classifier dut (
    .clk(clk), .rst(rst), .start(start), .feat_in(feat_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .valid(valid), .class_out(class_out),
    .score_out(score_out), .sat(sat)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid at cycle %0d required none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        chk("class_out", 32'(class_out), 32'(mon_e[19:17]));
        chk("score_out", 32'(score_out), 32'(mon_e[16:1]));
        chk("sat", 32'(sat), 32'(mon_e[0]));
        chk("latency", cyc, mon_t);
        chk("busy_at_valid", 32'(busy), 32'd0);
      end
    end
  end

  // driver tasks
  function automatic logic [F*DW-1:0] pack(input logic [DW-1:0] x0, x1, x2, x3, x4);
    return {x4, x3, x2, x1, x0};
  endfunction

  task automatic wr(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clear_all();
    for (int a = 0; a < 30; a++) wr(a, 16'h0000);
  endtask

  task automatic set_class(input int c, input logic [DW-1:0] w0, w1, w2, w3, w4, b);
    wr(c*6 + 0, w0); wr(c*6 + 1, w1); wr(c*6 + 2, w2);
    wr(c*6 + 3, w3); wr(c*6 + 4, w4); wr(c*6 + 5, b);
  endtask

  task automatic run(input logic [F*DW-1:0] x, input logic [CW-1:0] c,
                     input logic [DW-1:0] s, input logic sv);
    @(negedge clk);
    feat_in = x;
    start = 1'b1;
    exp_q.push_back({c, s, sv});
    exp_t_q.push_back(cyc + LAT);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results required 0", exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic load_ramp();
    clear_all();
    for (int c = 0; c < 5; c++) wr(c*6 + 5, DW'(c * 256));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; feat_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_class", 32'(class_out), 0);
    chk("rst_score", 32'(score_out), 0);
    chk("rst_sat", 32'(sat), 0);
    rst = 1'b0;

    // bias ramp wins at the top class
    load_ramp();
    run(pack(16'h1234, 16'hABCD, 16'h0F0F, 16'h8001, 16'h7FFF), 3'd4, 16'h0400, 1'b0);
    wait_done();

    // everything zero: tie keeps class 0
    clear_all();
    run(pack(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500), 3'd0, 16'h0000, 1'b0);
    wait_done();

    // class 2 = 1*1 + 1*2 = 3.0; others -1.0
    for (int c = 0; c < 5; c++) wr(c*6 + 5, 16'hFF00);
    set_class(2, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run(pack(16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'h0000), 3'd2, 16'h0300, 1'b0);
    wait_done();
    // negated x: class 2 = -3.0, four-way tie at -1.0 goes to class 0
    run(pack(16'hFF00, 16'hFE00, 16'h0000, 16'h0000, 16'h0000), 3'd0, 16'hFF00, 1'b0);
    wait_done();

    // every feature lane: 1.0 + 1.0 - 0.5 + 1.0 + 1.0 + 0.0625 = 3.5625
    clear_all();
    set_class(1, 16'h0200, 16'h0100, 16'h0100, 16'h0080, 16'h0400, 16'h0010);
    run(pack(16'h0080, 16'h0100, 16'hFF80, 16'h0200, 16'h0040), 3'd1, 16'h0390, 1'b0);
    wait_done();

    // positive saturation on class 0, others at -128.0
    clear_all();
    wr(0, 16'h7FFF);
    for (int c = 1; c < 5; c++) wr(c*6 + 5, 16'h8000);
    run(pack(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 3'd0, 16'h7FFF, 1'b1);
    wait_done();

    // reset ten cycles into a run aborts it
    load_ramp();
    @(negedge clk);
    feat_in = pack(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_mid_run", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(valid), 0);
    chk("abort_class", 32'(class_out), 0);
    chk("abort_score", 32'(score_out), 0);
    chk("abort_sat", 32'(sat), 0);
    repeat (40) @(negedge clk);
    run(pack(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100), 3'd4, 16'h0400, 1'b0);
    wait_done();

    // start and write while busy are both ignored
    run(pack(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 3'd4, 16'h0400, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'h7000;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);
    run(pack(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 3'd4, 16'h0400, 1'b0);
    wait_done();

    // out-of-range addresses are dropped
    wr(30, 16'h7FFF);
    wr(31, 16'h7FFF);
    run(pack(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 3'd4, 16'h0400, 1'b0);
    wait_done();

    // write in the accept cycle is seen by that run: bias[0] = 5.0
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'h0500;
    feat_in = pack(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    start = 1'b1;
    exp_q.push_back({3'd0, 16'h0500, 1'b0});
    exp_t_q.push_back(cyc + LAT);
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_done();

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svm_linear_classifier.md
Name: svm_linear_classifier

Overview:
- Parametrised linear multi-class SVM inference engine for the e-nose classifier path.
- Computes score[c] = bias[c] + sum_f w[c][f]*x[f] for every class using one shared signed fixed-point MAC, time-multiplexed over classes and features.
- Returns the argmax class index and its score.
- Weights and biases are runtime-loadable through a write port; reset does not clear them.
- Start/busy/valid handshake for sequencing by the sensor front-end controller.

Parameters:
- DATA_W, 16, width of features, weights, biases and score (signed two's complement).
- FRAC_W, 8, fractional bits of the Q format shared by all of the above.
- NUM_FEAT, 5, features per sample (F).
- NUM_CLASS, 5, number of classes (C).
- Derived (localparam): CLS_W = max(1, clog2(C)); ADDR_W = clog2(C*(F+1)); ACC_W = 2*DATA_W + clog2(F+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request inference; accepted only when busy==0.
- feat_in  in  NUM_FEAT*DATA_W  packed features; x[f] = feat_in[f*DATA_W +: DATA_W]; sampled at start accept.
- wr_en  in  1  weight/bias write strobe.
- wr_addr  in  ADDR_W  c*(F+1)+f; f<F selects w[c][f], f==F selects bias[c].
- wr_data  in  DATA_W  write data.
- busy  out  1  high from the cycle after accept until valid.
- valid  out  1  one-cycle pulse when the result is ready.
- class_out  out  CLS_W  argmax class index; held until the next valid.
- score_out  out  DATA_W  winning score; held until the next valid.
- sat  out  1  any class score saturated in the last run; held until the next valid.

Behaviour:
- Reset (clk edge with rst=1): state IDLE; busy=0, valid=0, class_out=0, score_out=0, sat=0; counters cleared. Weight/bias storage is not cleared.
- Reset mid-operation: the run is aborted immediately, no valid is produced, and the next start is accepted normally.
- States: IDLE -> MAC -> CMP -> (MAC for next class | DONE) -> IDLE.
- IDLE:
  - start=1: latch feat_in, set class counter c=0 and feature counter f=0, go to MAC, busy=1.
  - start while busy=1: ignored.
- MAC (F cycles per class):
  - f==0: acc = (sext(bias[c]) << FRAC_W) + w[c][0]*x[0].
  - f>0: acc += w[c][f]*x[f].
  - Products are full 2*DATA_W signed values. acc is ACC_W wide, so no internal overflow is possible.
  - After f==F-1, go to CMP.
- CMP (1 cycle):
  - s = acc >>> FRAC_W (arithmetic shift), saturated to the DATA_W signed range. Saturation sets the run's sat flag.
  - c==0, or s > best (strict): best=s, best_idx=c.
  - Ties keep the lower index.
  - If c==C-1, go to DONE; else c++, f=0, go to MAC.
- DONE (1 cycle): class_out=best_idx, score_out=best, sat=run flag, valid=1, busy=0; then IDLE.
- Latency: valid is asserted exactly C*(F+1)+1 cycles after the accept edge (31 with the defaults). Back-to-back: start is accepted in the cycle after valid.
- Writes:
  - wr_en while busy=0: the addressed entry is written at the clock edge and is visible to a start accepted on the next edge.
  - wr_en while busy=1: ignored, so weights stay frozen during a run.
  - wr_addr >= C*(F+1): ignored.
  - wr_en and start in the same cycle: the write takes effect and the run uses the new value.
- C==1: class_out is constant 0.

Test Plan (defaults, 1.0 = 16'h0100):
- All weights 0, bias[c]=c*16'h0100, x=anything, pulse start -> valid exactly 31 cycles later; class_out=4, score_out=16'h0400, sat=0.
- All weights/biases 0 -> class_out=0 (tie rule), score_out=0.
- x=[0100,0200,0,0,0]; w[2]=[0100,0100,0,0,0], bias[2]=0; other classes w=0, bias=16'hFF00 (-1.0) -> class_out=2, score_out=16'h0300. Negative path: negate x -> class_out=0, score_out=16'hFF00.
- w[0][0]=x[0]=16'h7FFF, other classes bias=16'h8000 -> score_out=16'h7FFF, sat=1, class_out=0.
- Assert rst 10 cycles into a run -> busy=0 and outputs 0 the next cycle, no valid; rerun of the first scenario without reloading weights -> class_out=4.
- start pulse and wr_en (bias[0]=16'h7000) while busy -> neither has effect; first result unchanged, exactly one valid, busy drops for at least one cycle.
